max_pool_stream: RTL

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

---
 rtl/max_pool_stream.sv | 107 ++++++++++
 1 files changed

// File: rtl/max_pool_stream.sv
// Streaming max/min pooling over non-overlapping windows of WINDOW signed samples.
// Reports the pooled value and the position of the first sample that achieved it.
module max_pool_stream #(
  parameter int DATA_WIDTH = 20,
  parameter int WINDOW     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [$clog2(WINDOW)-1:0]    out_idx
);

  localparam int IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]              cnt;
  logic signed [DATA_WIDTH-1:0]  acc_p0;
  logic [IDX_W-1:0]              best_p0;
  logic                          mode_p0;

  logic                          accept;
  logic                          last_accept;
  logic                          take;
  logic signed [DATA_WIDTH-1:0]  win_data;
  logic [IDX_W-1:0]              win_idx;

  // Strict compare so that ties keep the earlier sample.
  function automatic logic beats(input logic signed [DATA_WIDTH-1:0] cand,
                                 input logic signed [DATA_WIDTH-1:0] cur,
                                 input logic                         use_min);
    return use_min ? (cand < cur) : (cand > cur);
  endfunction

  assign accept      = in_valid & in_ready & ~flush;
  assign last_accept = accept & (cnt == LAST_IDX);
  assign take        = beats(in_data, acc_p0, mode_p0);
  assign win_data    = take ? in_data : acc_p0;
  assign win_idx     = take ? cnt : best_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (last_accept) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Stage p0: running best of the window; result registered on the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_p0   <= '0;
      best_p0  <= '0;
      mode_p0  <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else if (state == ACC) begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        if (cnt == '0) begin
          acc_p0  <= in_data;
          best_p0 <= '0;
          mode_p0 <= mode;
          cnt     <= cnt + IDX_W'(1);
        end else if (cnt == LAST_IDX) begin
          out_data <= win_data;
          out_idx  <= win_idx;
          cnt      <= '0;
        end else begin
          acc_p0  <= win_data;
          best_p0 <= win_idx;
          cnt     <= cnt + IDX_W'(1);
        end
      end
    end
  end

endmodule
